// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding uart_controller: buffers producer bytes and issues them one
// at a time on send_sig/send_data, pacing on busy_sending, with sticky overflow/timeout flags.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                  clk100mhz,
    input  logic                  cpu_resetn,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  tx_timeout,
    input  logic                  clr_err,
    output logic                  send_sig,
    output logic [7:0]            send_data,
    input  logic                  busy_sending
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_C   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE_C = (DEPTH_LOG2 + 1)'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE_C = DEPTH_LOG2'(1'b1);
    localparam logic [7:0]            TIMEOUT_C = 8'(BUSY_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_STROBE    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    state_t                state_r;
    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2:0]   count_nxt_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  overflow_r;
    logic                  tx_timeout_r;
    logic                  send_sig_r;
    logic [7:0]            send_data_r;
    logic [7:0]            tmo_cnt_r;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  tmo_hit_s;

    // Handshake decode: a full FIFO still accepts a write when the head leaves that cycle
    always_comb begin
        pop_s     = (state_r == ST_IDLE) && !empty_r;
        push_s    = wr_en && (!full_r || pop_s);
        drop_s    = wr_en && full_r && !pop_s;
        tmo_hit_s = (state_r == ST_WAIT_BUSY) && !busy_sending &&
                    ((tmo_cnt_r + 8'd1) == TIMEOUT_C);
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Byte storage; contents need no reset because pointers and count define validity
    always_ff @(posedge clk100mhz) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered full/empty status
    always_ff @(posedge clk100mhz) begin
        if (!cpu_resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == DEPTH_C);
            empty_r <= (count_nxt_s == '0);
        end
    end

    // Sticky error flags; clearing wins over a same-cycle set
    always_ff @(posedge clk100mhz) begin
        if (!cpu_resetn) begin
            overflow_r   <= 1'b0;
            tx_timeout_r <= 1'b0;
        end else if (clr_err) begin
            overflow_r   <= 1'b0;
            tx_timeout_r <= 1'b0;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (tmo_hit_s) begin
                tx_timeout_r <= 1'b1;
            end
        end
    end

    // Transmit sequencer: pop, let send_data settle, strobe, then follow busy_sending
    always_ff @(posedge clk100mhz) begin
        if (!cpu_resetn) begin
            state_r     <= ST_IDLE;
            send_sig_r  <= 1'b0;
            send_data_r <= 8'h00;
            tmo_cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    send_sig_r <= 1'b0;
                    if (pop_s) begin
                        send_data_r <= mem_r[rd_ptr_r];
                        state_r     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    send_sig_r <= 1'b1;
                    state_r    <= ST_STROBE;
                end
                ST_STROBE: begin
                    send_sig_r <= 1'b0;
                    tmo_cnt_r  <= 8'd0;
                    state_r    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    send_sig_r <= 1'b0;
                    if (busy_sending) begin
                        state_r <= ST_WAIT_DONE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                        if (tmo_hit_s) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    send_sig_r <= 1'b0;
                    if (!busy_sending) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    send_sig_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign full       = full_r;
    assign empty      = empty_r;
    assign count      = count_r;
    assign overflow   = overflow_r;
    assign tx_timeout = tx_timeout_r;
    assign send_sig   = send_sig_r;
    assign send_data  = send_data_r;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, directed multi-cycle sequences and random traffic,
// all checked every cycle against a timestamp-based transaction model.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int T = 15;

    logic       clk100mhz = 1'b0;
    logic       cpu_resetn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_timeout;
    logic       clr_err;
    logic       send_sig;
    logic [7:0] send_data;
    logic       busy_sending;

    always #5 clk100mhz = ~clk100mhz;

    uart_tx_fifo #(.DEPTH_LOG2(4), .BUSY_TIMEOUT(T)) dut (
        .clk100mhz(clk100mhz), .cpu_resetn(cpu_resetn), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .tx_timeout(tx_timeout), .clr_err(clr_err), .send_sig(send_sig),
        .send_data(send_data), .busy_sending(busy_sending)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: byte queue plus edge timestamps of the transfer in flight
    logic [7:0] mq[$];
    bit         m_inflight;
    int         m_pop_e;
    bit         m_got_busy;
    int         m_strobe_e;
    logic [7:0] m_last;
    bit         m_ovf;
    bit         m_tmo;

    bit         bsy_en;
    bit         busy_hold;
    int         bd;
    int         bl;
    logic [7:0] obs[$];

    typedef struct {
        logic       rn;
        logic       we;
        logic [7:0] wd;
        logic [4:0] e_count;
        logic       e_empty;
        logic       e_sig;
        logic [7:0] e_data;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int n, input logic rn, input logic we,
                              input logic [7:0] wd, input logic bz, input logic clr);
        bit full_b, pop, ovf_ev, tmo_ev;
        if (!rn) begin
            mq.delete();
            m_inflight = 1'b0; m_got_busy = 1'b0; m_strobe_e = -1;
            m_last = 8'h00; m_ovf = 1'b0; m_tmo = 1'b0;
            return;
        end
        full_b = (mq.size() == 16);
        pop    = !m_inflight && (mq.size() > 0);
        ovf_ev = 1'b0;
        tmo_ev = 1'b0;
        if (m_inflight) begin
            if (m_got_busy) begin
                if (!bz) m_inflight = 1'b0;
            end else if (n >= m_pop_e + 3) begin
                if (bz) m_got_busy = 1'b1;
                else if (n == m_pop_e + 2 + T) begin
                    tmo_ev = 1'b1;
                    m_inflight = 1'b0;
                end
            end
        end
        if (pop) begin
            m_last = mq.pop_front();
            m_inflight = 1'b1; m_pop_e = n; m_got_busy = 1'b0; m_strobe_e = n + 1;
        end
        if (we) begin
            if (full_b && !pop) ovf_ev = 1'b1;
            else mq.push_back(wd);
        end
        if (clr) begin
            m_ovf = 1'b0; m_tmo = 1'b0;
        end else begin
            if (ovf_ev) m_ovf = 1'b1;
            if (tmo_ev) m_tmo = 1'b1;
        end
    endtask

    task automatic tick(input logic we, input logic [7:0] wd, input logic clr);
        logic bz;
        bz = busy_hold || (bsy_en && m_strobe_e >= 0 && cyc >= m_strobe_e + bd &&
                           cyc < m_strobe_e + bd + bl);
        wr_en = we; wr_data = wd; clr_err = clr; busy_sending = bz;
        @(posedge clk100mhz);
        cyc++;
        model_step(cyc, cpu_resetn, we, wd, bz, clr);
        #1;
        check("count", count, mq.size());
        check("full", full, mq.size() == 16);
        check("empty", empty, mq.size() == 0);
        check("overflow", overflow, m_ovf);
        check("tx_timeout", tx_timeout, m_tmo);
        check("send_sig", send_sig, m_strobe_e == cyc);
        check("send_data", send_data, m_last);
        if (send_sig === 1'b1) obs.push_back(send_data);
    endtask

    initial begin
        int blk_bd[5];
        bit found;
        logic [7:0] exp_b;
        bsy_en = 1'b0; busy_hold = 1'b0; bd = 2; bl = 3;
        m_strobe_e = -1; m_last = 8'h00;
        cpu_resetn = 1'b0;

        // reset then first-byte latency, hand-derived expectations
        tbl[0] = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 1'b1, 8'h55, 5'd1, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h55};
        tbl[4] = '{1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b1, 8'h55};
        tbl[5] = '{1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h55};
        for (int i = 0; i < 6; i++) begin
            cpu_resetn = tbl[i].rn;
            tick(tbl[i].we, tbl[i].wd, 1'b0);
            check("tbl_count", count, tbl[i].e_count);
            check("tbl_empty", empty, tbl[i].e_empty);
            check("tbl_sig", send_sig, tbl[i].e_sig);
            check("tbl_data", send_data, tbl[i].e_data);
        end
        repeat (20) tick(1'b0, 8'h00, 1'b0);
        check("first_tmo", tx_timeout, 1'b1);
        tick(1'b0, 8'h00, 1'b1);

        // burst fill behind a held transfer, overflow drop, clr_err, ordered drain
        obs.delete();
        bsy_en = 1'b1; bd = 2; bl = 3;
        tick(1'b1, 8'hE0, 1'b0);
        busy_hold = 1'b1;
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), 1'b0);
        check("burst_full", full, 1'b1);
        check("burst_count", count, 5'd16);
        repeat (3) tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'hAA, 1'b0);
        check("drop_ovf", overflow, 1'b1);
        check("drop_count", count, 5'd16);
        tick(1'b0, 8'h00, 1'b1);
        check("clr_ovf", overflow, 1'b0);
        busy_hold = 1'b0;
        repeat (200) tick(1'b0, 8'h00, 1'b0);
        check("burst_nstrobe", obs.size(), 17);
        for (int i = 0; i < 17; i++) begin
            exp_b = (i == 0) ? 8'hE0 : 8'(i - 1);
            if (i < obs.size()) check("burst_order", obs[i], exp_b);
        end
        check("burst_empty", empty, 1'b1);
        check("burst_ovf", overflow, 1'b0);

        // busy never rises: one strobe, timeout, then a normal byte
        obs.delete();
        bsy_en = 1'b0;
        tick(1'b1, 8'h3C, 1'b0);
        repeat (25) tick(1'b0, 8'h00, 1'b0);
        check("tmo_flag", tx_timeout, 1'b1);
        check("tmo_nstrobe", obs.size(), 1);
        tick(1'b0, 8'h00, 1'b1);
        bsy_en = 1'b1;
        tick(1'b1, 8'h3D, 1'b0);
        repeat (15) tick(1'b0, 8'h00, 1'b0);
        check("tmo_next", obs.size(), 2);
        if (obs.size() == 2) check("tmo_next_data", obs[1], 8'h3D);

        // push and pop together while full, pointers wrapping
        obs.delete();
        busy_hold = 1'b1;
        tick(1'b1, 8'h80, 1'b0);
        for (int i = 0; i < 16; i++) tick(1'b1, 8'hA0 + 8'(i), 1'b0);
        check("pp_count", count, 5'd16);
        busy_hold = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (!m_inflight && mq.size() > 0) found = 1'b1;
            else tick(1'b0, 8'h00, 1'b0);
        end
        check("pp_reach_idle", found, 1'b1);
        tick(1'b1, 8'hB0, 1'b0);
        check("pp_count_hold", count, 5'd16);
        check("pp_ovf", overflow, 1'b0);
        repeat (250) tick(1'b0, 8'h00, 1'b0);
        check("pp_nstrobe", obs.size(), 18);
        for (int i = 0; i < 18; i++) begin
            exp_b = (i == 0) ? 8'h80 : ((i == 17) ? 8'hB0 : 8'hA0 + 8'(i - 1));
            if (i < obs.size()) check("pp_order", obs[i], exp_b);
        end

        // reset while a byte is in flight and five are queued
        obs.delete();
        busy_hold = 1'b1;
        for (int i = 0; i < 6; i++) tick(1'b1, 8'hC0 + 8'(i), 1'b0);
        repeat (3) tick(1'b0, 8'h00, 1'b0);
        check("rst_pre_count", count, 5'd5);
        cpu_resetn = 1'b0;
        repeat (2) tick(1'b0, 8'h00, 1'b0);
        check("rst_count", count, 5'd0);
        check("rst_sig", send_sig, 1'b0);
        check("rst_data", send_data, 8'h00);
        cpu_resetn = 1'b1;
        busy_hold = 1'b0;
        repeat (30) tick(1'b0, 8'h00, 1'b0);
        check("rst_nostrobe", obs.size(), 1);

        // random traffic against the model, sweeping busy delay across the timeout edge
        blk_bd = '{0, 1, 3, 15, 16};
        for (int b = 0; b < 5; b++) begin
            bd = blk_bd[b];
            bl = 1 + $urandom_range(0, 4);
            for (int i = 0; i < 150; i++) begin
                cpu_resetn = ($urandom_range(0, 299) != 0);
                tick($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 99) < 4);
            end
            cpu_resetn = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
